// File: rtl/router_fifo.sv
// router_fifo: per-port output buffer of the 1x3 router with packet-length tracking
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_active
);
  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [6:0]     cnt;
  logic [WIDTH:0] rd_word;
  logic           wr_ok, rd_ok;
  assign empty      = wr_ptr == rd_ptr;
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_ok      = write_enb && !full;
  assign rd_ok      = read_enb && !empty;
  assign rd_word    = mem[rd_ptr[AW-1:0]];
  assign pkt_active = cnt != 7'd0;
  // storage: each entry keeps the byte plus the header flag in the top bit
  always_ff @(posedge clock or posedge reset)
    if (reset)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wr_ok && !soft_reset)
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
  // pointers, registered read data and the payload down-counter; flush wins over traffic
  always_ff @(posedge clock or posedge reset)
    if (reset || soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      wr_ptr   <= wr_ok ? wr_ptr + (AW+1)'(1) : wr_ptr;
      rd_ptr   <= rd_ok ? rd_ptr + (AW+1)'(1) : rd_ptr;
      data_out <= rd_ok ? rd_word[WIDTH-1:0] : (cnt == 7'd0 ? '0 : data_out);
      cnt      <= !rd_ok ? cnt :
                  rd_word[WIDTH] ? 7'(rd_word[7:2]) + 7'd1 :
                  cnt != 7'd0 ? cnt - 7'd1 : cnt;
    end
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed self-checking bench for router_fifo
module tb_router_fifo;
  logic       clock = 0;
  logic       reset = 1;
  logic       soft_reset = 0;
  logic       write_enb = 0;
  logic       read_enb = 0;
  logic       lfd_state = 0;
  logic [7:0] data_in = 0;
  logic [7:0] data_out;
  logic       full, empty, pkt_active;
  logic [7:0] q[$];
  logic [7:0] prev;
  int         n_cmp = 0;
  int         n_err = 0;

  router_fifo dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset), .write_enb(write_enb),
    .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in), .data_out(data_out),
    .full(full), .empty(empty), .pkt_active(pkt_active)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one cycle from a negedge; outputs are stable at the following negedge
  task automatic step(input logic we, input logic re, input logic lfd, input logic [7:0] d);
    write_enb = we;
    read_enb  = re;
    lfd_state = lfd;
    data_in   = d;
    @(negedge clock);
    write_enb = 0;
    read_enb  = 0;
    lfd_state = 0;
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    step(1, 0, lfd, d);
    q.push_back(d);
  endtask

  task automatic rd(input string tag);
    logic [7:0] e;
    e = q.pop_front();
    step(0, 1, 0, 8'h00);
    chk(tag, data_out, e);
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_pkt", pkt_active, 0);
    chk("rst_dout", data_out, 0);

    // 1: header 0D (len 3) + 3 payload + parity
    wr(8'h0D, 1);
    wr(8'h11, 0);
    wr(8'h22, 0);
    wr(8'h33, 0);
    wr(8'h0D, 0);
    chk("t1_empty", empty, 0);
    rd("t1_hdr");
    chk("t1_pkt_hdr", pkt_active, 1);
    rd("t1_p0");
    chk("t1_pkt_p0", pkt_active, 1);
    rd("t1_p1");
    rd("t1_p2");
    chk("t1_pkt_p2", pkt_active, 1);
    rd("t1_par");
    chk("t1_pkt_par", pkt_active, 0);
    step(0, 0, 0, 0);
    chk("t1_dout_zero", data_out, 0);
    chk("t1_empty_end", empty, 1);

    // 2: fill to 16, drop 17th, drain in order
    for (int i = 0; i < 16; i++) begin
      wr(8'h40 + 8'(i), 0);
      if (i == 14) chk("t2_full15", full, 0);
    end
    chk("t2_full16", full, 1);
    step(1, 0, 0, 8'hEE);
    chk("t2_full17", full, 1);
    for (int i = 0; i < 16; i++) rd("t2_rd");
    chk("t2_empty", empty, 1);
    chk("t2_full_end", full, 0);

    // 3: full with read+write: only the read happens
    for (int i = 0; i < 16; i++) wr(8'h50 + 8'(i), 0);
    chk("t3_full", full, 1);
    prev = q.pop_front();
    step(1, 1, 0, 8'hFF);
    chk("t3_dout", data_out, prev);
    chk("t3_full_after", full, 0);
    for (int i = 0; i < 15; i++) rd("t3_rd");
    chk("t3_empty", empty, 1);

    // 4: empty with read+write: only the write happens
    step(0, 0, 0, 0);
    prev = data_out;
    step(1, 1, 0, 8'h77);
    q.push_back(8'h77);
    chk("t4_dout_hold", data_out, prev);
    chk("t4_empty", empty, 0);
    rd("t4_rd");
    chk("t4_empty_end", empty, 1);

    // 5: hold 12, stream 8 with read+write, fill to 16 across the wrap, drain
    for (int i = 0; i < 12; i++) wr(8'hA0 + 8'(i), 0);
    for (int i = 0; i < 8; i++) begin
      prev = q.pop_front();
      q.push_back(8'hB0 + 8'(i));
      step(1, 1, 0, 8'hB0 + 8'(i));
      chk("t5_rw", data_out, prev);
      chk("t5_rw_full", full, 0);
    end
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i), 0);
    chk("t5_full", full, 1);
    for (int i = 0; i < 16; i++) rd("t5_rd");
    chk("t5_empty", empty, 1);
    chk("t5_nfull", full, 0);

    // 6: soft reset mid-packet
    wr(8'h09, 1);
    wr(8'h01, 0);
    wr(8'h02, 0);
    rd("t6_hdr");
    chk("t6_pkt", pkt_active, 1);
    soft_reset = 1;
    step(1, 1, 0, 8'h99);
    soft_reset = 0;
    q.delete();
    chk("t6_sr_empty", empty, 1);
    chk("t6_sr_pkt", pkt_active, 0);
    chk("t6_sr_dout", data_out, 0);

    // async reset between edges mid-packet
    wr(8'h05, 1);
    wr(8'hAA, 0);
    rd("t6_hdr2");
    chk("t6_pkt2", pkt_active, 1);
    #2 reset = 1;
    #1;
    chk("t6_ar_dout", data_out, 0);
    chk("t6_ar_empty", empty, 1);
    chk("t6_ar_pkt", pkt_active, 0);
    chk("t6_ar_full", full, 0);
    @(negedge clock);
    reset = 0;
    q.delete();
    wr(8'h3C, 0);
    chk("t6_post_empty", empty, 0);
    rd("t6_post_rd");
    chk("t6_post_pkt", pkt_active, 0);
    chk("t6_post_empty2", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
